// File: rtl/fifo_reader_pkg.sv
// Shared types and defaults for the FIFO read-side streaming engine.
// Imported by the skid buffer and the top-level reader.
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_PKT_LEN = 4;
  localparam int unsigned DEF_CNT_W   = 16;
  localparam int unsigned SKID_DEPTH  = 2;

  // Slots that will be occupied after this edge if nothing new is fetched:
  // buffered words plus the word in flight, minus the word leaving this cycle.
  function automatic logic [1:0] credits_used(input logic [1:0] occ,
                                              input logic       inflight,
                                              input logic       popping);
    logic [2:0] sum;
    sum = {1'b0, occ} + {2'b00, inflight} - {2'b00, popping};
    return sum[1:0];
  endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry skid buffer: entry 0 is always the head, pushes land at the tail.
// Simultaneous push and pop keep the occupancy unchanged.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [1:0]       occ_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [WIDTH-1:0] mem_d [SKID_DEPTH];
  logic [1:0]       occ_q, occ_d;

  always_comb begin
    // NOTE: every next-state variable gets its hold value first so no path leaves it unassigned (no latch).
    mem_d = mem_q;
    occ_d = occ_q;
    case ({push_i, pop_i})
      2'b10: begin
        mem_d[occ_q[0]] = push_data_i;
        occ_d           = occ_q + 2'd1;
      end
      2'b01: begin
        mem_d[0] = mem_q[1];
        occ_d    = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          mem_d[0] = mem_q[1];
          mem_d[1] = push_data_i;
        end else begin
          mem_d[0] = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= 2'd0;
      // NOTE: storage is reset only because the head drives out_data, which must read zero in reset.
      mem_q <= '{default: '0};
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      occ_q <= occ_d;
      mem_q <= mem_d;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = mem_q[0];

endmodule

// File: rtl/fifo_reader.sv
// Read-side engine for sync_fifo: prefetches words into a skid buffer and
// presents them as a valid/ready stream with packet framing and a word counter.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned PKT_LEN = DEF_PKT_LEN,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CNT_W-1:0] word_count,
  output logic             busy
);

  localparam int unsigned       BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  state_e            state_q, state_d;
  logic              inflight_q;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [1:0]        occ;
  logic              transfer;

  fifo_reader_skid #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst_n      (reset),
    .push_i     (inflight_q),
    .push_data_i(fifo_data),
    .pop_i      (transfer),
    .occ_o      (occ),
    .head_o     (out_data)
  );

  assign out_valid = (occ != 2'd0);
  assign transfer  = out_valid && out_ready;

  // Counting the departing head as free lets a fetch overlap each pop,
  // sustaining one word per cycle while a capture still never meets a full buffer.
  assign fifo_rd = (state_q == ST_RUN) && enable && !fifo_empty &&
                   (credits_used(occ, inflight_q, transfer) < 2'd2);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN:   if (!enable) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (enable) begin
          state_d = ST_RUN;
        end else if (!out_valid && !inflight_q) begin
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    beat_d  = beat_q;
    count_d = count_q;
    if (transfer) begin
      beat_d  = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      inflight_q <= 1'b0;
      beat_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rd;
      beat_q     <= beat_d;
      count_q    <= count_d;
    end
  end

  assign out_last   = out_valid && (beat_q == LAST_BEAT);
  assign word_count = count_q;
  assign busy       = (state_q != ST_IDLE) || out_valid || inflight_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a behavioural sync FIFO feeds the DUT, a per-cycle
// stream model checks order/framing/count, and directed scenarios pin literals.
module tb_fifo_reader;

  localparam int WIDTH   = 8;
  localparam int PKT_LEN = 4;
  localparam int CNT_W   = 16;
  localparam int MEM_N   = 2048;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             out_ready = 1'b0;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_rd;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic [CNT_W-1:0] word_count;
  logic             busy;

  logic [WIDTH-1:0] mem [MEM_N];
  int               wr_ptr = 0;
  int               rd_ptr = 0;

  int               n_cmp = 0;
  int               n_bad = 0;
  int               model_idx = 0;
  int               model_beat = 0;
  int               model_cnt = 0;
  int               rd_pulses = 0;
  logic [WIDTH-1:0] last_tag = '0;

  always #5 clk = ~clk;

  // Behavioural sync FIFO: data_out registered one cycle after an accepted read.
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (fifo_rd && !fifo_empty) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  fifo_reader #(
    .WIDTH  (WIDTH),
    .PKT_LEN(PKT_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd   (fifo_rd),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .word_count(word_count),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_write(input logic [WIDTH-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr      = wr_ptr + 1;
  endtask

  task automatic wait_valid(input int limit, input string name, output int waited);
    waited = 0;
    while (!out_valid && waited < limit) begin
      tick();
      waited++;
    end
    check(name, out_valid, 1);
  endtask

  task automatic wait_idle(input int limit, input string name);
    for (int i = 0; i < limit && busy; i++) tick();
    check(name, busy, 0);
  endtask

  task automatic wait_drained(input int limit, input string name);
    for (int i = 0; i < limit && model_idx != wr_ptr; i++) tick();
    check(name, model_idx, wr_ptr);
  endtask

  // Stream model: every delivered word is the next unread FIFO entry, framing
  // follows the delivered-word index modulo PKT_LEN, and the counter tracks transfers.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        model_idx  = rd_ptr;
        model_beat = 0;
        model_cnt  = 0;
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_rd", fifo_rd, 0);
        check("rst_count", word_count, 0);
        check("rst_busy", busy, 0);
      end else begin
        if (fifo_rd && !fifo_empty) rd_pulses++;
        check("rd_while_disabled", fifo_rd && !enable, 0);
        check("word_count", word_count, model_cnt[CNT_W-1:0]);
        if (out_valid) begin
          check("extra_word", model_idx < wr_ptr, 1);
          if (model_idx < wr_ptr) check("stream_data", out_data, mem[model_idx]);
          check("stream_last", out_last, model_beat == PKT_LEN - 1);
          if (out_ready) begin
            if (out_last) last_tag = out_data;
            model_idx++;
            model_beat = (model_beat + 1) % PKT_LEN;
            model_cnt++;
          end
        end else begin
          check("last_without_valid", out_last, 0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] t1 [4];
    int waited;
    int base;
    int written;

    t1 = '{8'h11, 8'h22, 8'h33, 8'h44};
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Back-to-back packet of four.
    for (int i = 0; i < 4; i++) fifo_write(t1[i]);
    out_ready = 1'b1;
    enable    = 1'b1;
    wait_valid(20, "t1_first_valid", waited);
    check("t1_latency", waited, 3);
    for (int k = 0; k < 4; k++) begin
      check("t1_valid", out_valid, 1);
      check("t1_data", out_data, t1[k]);
      check("t1_last", out_last, k == 3);
      tick();
    end
    check("t1_count", word_count, 4);
    enable = 1'b0;
    wait_idle(10, "t1_idle");

    // Consumer stall: only two prefetches, head held.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) fifo_write(8'hA0 + 8'(i));
    base   = rd_pulses;
    enable = 1'b1;
    repeat (8) tick();
    check("t2_pops", rd_pulses - base, 2);
    check("t2_valid", out_valid, 1);
    check("t2_hold", out_data, 8'hA0);
    check("t2_fifo_level", wr_ptr - rd_ptr, 4);
    out_ready = 1'b1;
    wait_drained(50, "t2_drained");
    check("t2_count", word_count, 10);

    // Disable with one buffered and one in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) fifo_write(8'hB0 + 8'(i));
    base = rd_pulses;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    #1;
    enable = 1'b0;
    check("t3_pops_at_disable", rd_pulses - base, 2);
    repeat (3) tick();
    check("t3_no_more_rd", rd_pulses - base, 2);
    check("t3_head", out_data, 8'hB0);
    check("t3_draining", busy, 1);
    out_ready = 1'b1;
    wait_idle(20, "t3_idle");
    check("t3_fifo_keeps", wr_ptr - rd_ptr, 2);
    check("t3_count", word_count, 12);

    // FIFO runs dry mid-packet; framing survives the gap.
    enable = 1'b1;
    wait_drained(30, "t4_first_half");
    repeat (5) tick();
    check("t4_stall", out_valid, 0);
    check("t4_busy", busy, 1);
    fifo_write(8'hC0);
    fifo_write(8'hC1);
    wait_drained(30, "t4_second_half");
    check("t4_last_tag", last_tag, 8'hC1);
    check("t4_count", word_count, 16);

    // Async reset with a full buffer.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) fifo_write(8'hD0 + 8'(i));
    base = rd_pulses;
    wait_valid(20, "t5_valid", waited);
    repeat (3) tick();
    check("t5_pops", rd_pulses - base, 2);
    check("t5_full_valid", out_valid, 1);
    reset = 1'b0;
    #1;
    check("t5_async_valid", out_valid, 0);
    check("t5_async_count", word_count, 0);
    check("t5_async_busy", busy, 0);
    repeat (2) tick();
    reset     = 1'b1;
    out_ready = 1'b1;
    wait_valid(20, "t5_resume_valid", waited);
    check("t5_resume_data", out_data, 8'hD2);
    wait_drained(30, "t5_drained");
    check("t5_count", word_count, 2);

    // Random traffic, 1000 words.
    reset = 1'b0;
    repeat (2) tick();
    reset   = 1'b1;
    enable  = 1'b1;
    written = 0;
    for (int c = 0; c < 20000 && model_cnt < 1000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (written < 1000 && $urandom_range(0, 1) == 1) begin
        fifo_write(8'($urandom_range(0, 255)));
        written++;
      end
      tick();
    end
    check("t6_delivered", model_cnt, 1000);
    check("t6_count", word_count, 1000);
    enable = 1'b0;
    out_ready = 1'b1;
    wait_idle(20, "t6_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
